// File: rtl/led_result_stream_tx_if.sv
// rtl/led_result_stream_tx_if.sv - AXI4-Stream bundle for the LED result transmitter
//
// Purpose: groups the stream handshake/data signals so the transmitter and its
// sink share one port.
// Signals:
//   TVALID  word valid (master -> slave)
//   TDATA   32-bit data word (master -> slave)
//   TSTRB   byte strobes, always all-ones (master -> slave)
//   TLAST   last word of a frame packet (master -> slave)
//   TREADY  sink ready (slave -> master)
// Modports: master (transmitter side), slave (sink side).

interface led_result_stream_tx_if;
  logic        TVALID;
  logic [31:0] TDATA;
  logic [3:0]  TSTRB;
  logic        TLAST;
  logic        TREADY;

  modport master (
    output TVALID,
    output TDATA,
    output TSTRB,
    output TLAST,
    input  TREADY
  );

  modport slave (
    input  TVALID,
    input  TDATA,
    input  TSTRB,
    input  TLAST,
    output TREADY
  );
endinterface

// File: rtl/led_result_stream_tx.sv
// rtl/led_result_stream_tx.sv - per-frame LED detection results to an AXI4-Stream sink
//
// Purpose: buffers detection hits and frame-end pulses from the led_detect
// pixel core in a result FIFO and streams them out, one packet per frame,
// with TLAST on the word that closes the frame.
// Optional feature macro: LED_TX_FRAME_HDR_EN -- when defined, every packet
// starts with a header word {8'hA5, frame_cnt[23:0]}.
// Ports:
//   ACLK, ARESET      clock, asynchronous active-high reset
//   det_valid         one-cycle hit strobe with det_x / det_y
//   frame_end         one-cycle strobe, frame finished
//   clear_stats       synchronous clear of drop_cnt / overflow
//   M_AXIS            stream master (TVALID/TDATA/TSTRB/TLAST/TREADY)
//   fifo_level        result entries held, including the one presented on M_AXIS
//   drop_cnt          saturating count of dropped hits
//   overflow          sticky, set by the first dropped hit

module led_result_stream_tx #(
  parameter int          FIFO_DEPTH = 16,
  parameter int          COORD_W    = 16,
  parameter logic [31:0] EOF_MARKER = 32'hFFFF_FFFF
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          det_valid,
  input  logic [COORD_W-1:0]            det_x,
  input  logic [COORD_W-1:0]            det_y,
  input  logic                          frame_end,
  input  logic                          clear_stats,
  led_result_stream_tx_if.master        M_AXIS,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_cnt,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

`ifdef LED_TX_FRAME_HDR_EN
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif

  state_t state, stateNext;

  // Entry layout: {last, data[31:0]}
  logic [32:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [LW-1:0] memCount;
  logic          eofPend, eofPendNext;

  logic        outValid, outLast, outIsEntry;
  logic [31:0] outData;

`ifdef LED_TX_FRAME_HDR_EN
  logic [23:0] frameCnt;
`endif

  logic        outAccept, canLoad, entryFree, spaceOk, memEmpty;
  logic        pushNow, dropHit, memWrite, loadEntry, loadFromMem;
  logic        entryState, loadOut, loadIsEntry;
  logic [32:0] pushWord, loadWord;
  logic [31:0] hitWord;

  assign hitWord   = {16'(det_y), 16'(det_x)};
  assign memEmpty  = (memCount == '0);
  assign outAccept = outValid && M_AXIS.TREADY;
  assign canLoad   = !outValid || M_AXIS.TREADY;
  // The word on the output counts toward the FIFO depth, so accepting it frees a slot.
  assign entryFree = outAccept && outIsEntry;
  assign spaceOk   = (fifo_level != FULL_LEVEL) || entryFree;

  // Push / drop decision. A pending frame end owns the first free slot.
  always_comb begin
    pushNow     = 1'b0;
    pushWord    = '0;
    dropHit     = 1'b0;
    eofPendNext = eofPend;
    if (eofPend) begin
      dropHit = det_valid;
      if (spaceOk) begin
        pushNow     = 1'b1;
        pushWord    = {1'b1, EOF_MARKER};
        eofPendNext = frame_end;
      end
    end else if (det_valid || frame_end) begin
      if (spaceOk) begin
        pushNow  = 1'b1;
        pushWord = det_valid ? {frame_end, hitWord} : {1'b1, EOF_MARKER};
      end else begin
        dropHit     = det_valid;
        eofPendNext = frame_end;
      end
    end
  end

  // Entries may enter the output stage only while no TLAST word is still waiting,
  // so the next packet (and its header) starts after the previous one completes.
`ifdef LED_TX_FRAME_HDR_EN
  assign entryState = (state == DATA) && !(outValid && outLast);
`else
  assign entryState = (state == IDLE) || ((state == DATA) && !(outValid && outLast));
`endif

  assign loadEntry   = canLoad && entryState && (!memEmpty || pushNow);
  assign loadFromMem = loadEntry && !memEmpty;
  // With nothing stored, an incoming entry goes straight to the output stage.
  assign memWrite    = pushNow && !(loadEntry && memEmpty);

  always_comb begin
    stateNext   = state;
    loadOut     = 1'b0;
    loadIsEntry = 1'b0;
    loadWord    = '0;
    if (loadEntry) begin
      loadOut     = 1'b1;
      loadIsEntry = 1'b1;
      loadWord    = memEmpty ? pushWord : mem[rdPtr];
    end
    case (state)
      IDLE: begin
`ifdef LED_TX_FRAME_HDR_EN
        if (!memEmpty) stateNext = HDR;
`else
        if (loadEntry) stateNext = DATA;
`endif
      end
`ifdef LED_TX_FRAME_HDR_EN
      HDR: begin
        if (canLoad) begin
          loadOut   = 1'b1;
          loadWord  = {1'b0, 8'hA5, frameCnt};
          stateNext = DATA;
        end
      end
`endif
      DATA: begin
        if (outAccept && outLast) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (memWrite) mem[wrPtr] <= pushWord;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= IDLE;
      wrPtr      <= '0;
      rdPtr      <= '0;
      memCount   <= '0;
      fifo_level <= '0;
      eofPend    <= 1'b0;
      outValid   <= 1'b0;
      outData    <= '0;
      outLast    <= 1'b0;
      outIsEntry <= 1'b0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
`ifdef LED_TX_FRAME_HDR_EN
      frameCnt   <= '0;
`endif
    end else begin
      state      <= stateNext;
      eofPend    <= eofPendNext;
      if (memWrite)    wrPtr <= wrPtr + AW'(1);
      if (loadFromMem) rdPtr <= rdPtr + AW'(1);
      memCount   <= memCount + LW'(memWrite) - LW'(loadFromMem);
      fifo_level <= fifo_level + LW'(pushNow) - LW'(entryFree);

      if (loadOut) begin
        outValid   <= 1'b1;
        outData    <= loadWord[31:0];
        outLast    <= loadWord[32];
        outIsEntry <= loadIsEntry;
      end else if (outAccept) begin
        outValid   <= 1'b0;
        outIsEntry <= 1'b0;
      end

      if (clear_stats) begin
        drop_cnt <= '0;
        overflow <= 1'b0;
      end else if (dropHit) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end

`ifdef LED_TX_FRAME_HDR_EN
      if (outAccept && outLast) frameCnt <= frameCnt + 24'd1;
`endif
    end
  end

  assign M_AXIS.TVALID = outValid;
  assign M_AXIS.TDATA  = outData;
  assign M_AXIS.TLAST  = outLast;
  assign M_AXIS.TSTRB  = 4'b1111;

endmodule

// File: tb/tb_led_result_stream_tx.sv
// tb/tb_led_result_stream_tx.sv - self-checking bench for led_result_stream_tx

module tb_led_result_stream_tx;

  logic        tb_ACLK = 1'b0;
  logic        tb_ARESET = 1'b1;
  logic        detValid = 1'b0;
  logic [15:0] detX = '0;
  logic [15:0] detY = '0;
  logic        frameEnd = 1'b0;
  logic        clearStats = 1'b0;
  logic [4:0]  fifoLevel;
  logic [15:0] dropCnt;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [32:0] rxQ[$];
  logic [32:0] expQ[$];
  logic [23:0] expFrame = '0;

  led_result_stream_tx_if axisIf();

  always #5 tb_ACLK = ~tb_ACLK;

  led_result_stream_tx dut (
    .ACLK        (tb_ACLK),
    .ARESET      (tb_ARESET),
    .det_valid   (detValid),
    .det_x       (detX),
    .det_y       (detY),
    .frame_end   (frameEnd),
    .clear_stats (clearStats),
    .M_AXIS      (axisIf),
    .fifo_level  (fifoLevel),
    .drop_cnt    (dropCnt),
    .overflow    (overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Captures accepted words and checks that a stalled word holds steady.
  logic        holdPrev = 1'b0;
  logic [31:0] prevData;
  logic        prevLast;
  always @(negedge tb_ACLK) begin
    if (tb_ARESET) begin
      holdPrev = 1'b0;
    end else begin
      if (holdPrev) begin
        check("hold_tvalid", 64'(axisIf.TVALID), 64'd1);
        check("hold_tdata", 64'(axisIf.TDATA), 64'(prevData));
        check("hold_tlast", 64'(axisIf.TLAST), 64'(prevLast));
      end
      if (axisIf.TVALID && axisIf.TREADY) rxQ.push_back({axisIf.TLAST, axisIf.TDATA});
      holdPrev = axisIf.TVALID && !axisIf.TREADY;
      prevData = axisIf.TDATA;
      prevLast = axisIf.TLAST;
    end
  end

  task automatic tick();
    @(posedge tb_ACLK);
    #1;
  endtask

  task automatic drive(input logic dv, input logic fe, input logic [15:0] x, input logic [15:0] y);
    detValid = dv;
    frameEnd = fe;
    detX     = x;
    detY     = y;
    tick();
    detValid = 1'b0;
    frameEnd = 1'b0;
  endtask

  task automatic expHeader();
`ifdef LED_TX_FRAME_HDR_EN
    expQ.push_back({1'b0, 8'hA5, expFrame});
`endif
  endtask

  task automatic expWord(input logic [31:0] data, input logic last);
    expQ.push_back({last, data});
    if (last) expFrame++;
  endtask

  task automatic expectStream(input string name);
    int budget = 400;
    while (rxQ.size() < expQ.size() && budget > 0) begin
      tick();
      budget--;
    end
    repeat (4) tick();
    check($sformatf("%s_count", name), 64'(rxQ.size()), 64'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++) begin
      if (i < rxQ.size())
        check($sformatf("%s_word%0d", name, i), 64'(rxQ[i]), 64'(expQ[i]));
    end
    rxQ.delete();
    expQ.delete();
  endtask

  typedef struct {
    logic        dv;
    logic        fe;
    logic [15:0] x;
    logic [15:0] y;
    logic [31:0] expData;
    logic        expLast;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    bit newFrame;

    vecs[0] = '{1'b1, 1'b0, 16'd3,      16'd5,      32'h0005_0003, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 16'd7,      16'd9,      32'h0009_0007, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 16'd0,      16'd0,      32'hFFFF_FFFF, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 16'd2,      16'd4,      32'h0004_0002, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 16'hFFFF,   16'h0000,   32'h0000_FFFF, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 16'h0000,   16'hFFFF,   32'hFFFF_0000, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 16'h1234,   16'hABCD,   32'hABCD_1234, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 16'h5555,   16'h6666,   32'hFFFF_FFFF, 1'b1};

    axisIf.TREADY = 1'b0;
    tb_ARESET = 1'b1;
    repeat (2) @(posedge tb_ACLK);
    #1;
    tb_ARESET = 1'b0;
    tick();

    // Reset state
    check("rst_tvalid", 64'(axisIf.TVALID), 64'd0);
    check("rst_tdata",  64'(axisIf.TDATA),  64'd0);
    check("rst_tlast",  64'(axisIf.TLAST),  64'd0);
    check("rst_tstrb",  64'(axisIf.TSTRB),  64'hF);
    check("rst_level",  64'(fifoLevel),     64'd0);
    check("rst_drop",   64'(dropCnt),       64'd0);
    check("rst_ovf",    64'(overflow),      64'd0);

    // Table: back-to-back frames with TREADY held high
    axisIf.TREADY = 1'b1;
    newFrame = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].dv, vecs[i].fe, vecs[i].x, vecs[i].y);
      if (newFrame) expHeader();
      expWord(vecs[i].expData, vecs[i].expLast);
      newFrame = vecs[i].expLast;
    end
    expectStream("table");
    check("table_level_drained", 64'(fifoLevel), 64'd0);
    check("table_tvalid_idle", 64'(axisIf.TVALID), 64'd0);

    // Backpressure for 10 cycles mid-packet
    axisIf.TREADY = 1'b0;
    drive(1'b1, 1'b0, 16'd10, 16'd20);
`ifndef LED_TX_FRAME_HDR_EN
    check("latency_tvalid", 64'(axisIf.TVALID), 64'd1);
    check("latency_tdata", 64'(axisIf.TDATA), 64'h0014_000A);
`endif
    drive(1'b1, 1'b0, 16'd11, 16'd21);
    drive(1'b0, 1'b1, 16'd0, 16'd0);
    repeat (10) tick();
    check("bp_tvalid", 64'(axisIf.TVALID), 64'd1);
    check("bp_level", 64'(fifoLevel), 64'd3);
    expHeader();
    expWord(32'h0014_000A, 1'b0);
    expWord(32'h0015_000B, 1'b0);
    expWord(32'hFFFF_FFFF, 1'b1);
    axisIf.TREADY = 1'b1;
    expectStream("bp");

    // Overflow: 20 hits into a stalled stream, then frame end
    axisIf.TREADY = 1'b0;
    for (int i = 1; i <= 20; i++) drive(1'b1, 1'b0, 16'(i), 16'(16'h0100 + i));
    drive(1'b0, 1'b1, 16'd0, 16'd0);
    repeat (3) tick();
    check("ovf_drop4", 64'(dropCnt), 64'd4);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_level_full", 64'(fifoLevel), 64'd16);
    // Clear wins over a same-cycle drop
    clearStats = 1'b1;
    drive(1'b1, 1'b0, 16'h7777, 16'h7777);
    clearStats = 1'b0;
    check("clr_drop", 64'(dropCnt), 64'd0);
    check("clr_ovf", 64'(overflow), 64'd0);
    drive(1'b1, 1'b0, 16'h8888, 16'h8888);
    check("drop_after_clr", 64'(dropCnt), 64'd1);
    check("ovf_after_clr", 64'(overflow), 64'd1);
    expHeader();
    for (int i = 1; i <= 16; i++) expWord({16'(16'h0100 + i), 16'(i)}, 1'b0);
    expWord(32'hFFFF_FFFF, 1'b1);
    axisIf.TREADY = 1'b1;
    expectStream("ovf");
    check("ovf_level_drained", 64'(fifoLevel), 64'd0);

    // Reset in the middle of a stalled packet
    axisIf.TREADY = 1'b0;
    drive(1'b1, 1'b0, 16'd40, 16'd50);
    drive(1'b1, 1'b0, 16'd41, 16'd51);
    repeat (2) tick();
    check("pre_rst_tvalid", 64'(axisIf.TVALID), 64'd1);
    tb_ARESET = 1'b1;
    #2;
    check("midrst_tvalid", 64'(axisIf.TVALID), 64'd0);
    check("midrst_level", 64'(fifoLevel), 64'd0);
    tick();
    tb_ARESET = 1'b0;
    tick();
    check("postrst_tvalid", 64'(axisIf.TVALID), 64'd0);
    rxQ.delete();
    expFrame = '0;
    axisIf.TREADY = 1'b1;
    drive(1'b1, 1'b0, 16'd1, 16'd2);
    drive(1'b0, 1'b1, 16'd0, 16'd0);
    expHeader();
    expWord(32'h0002_0001, 1'b0);
    expWord(32'hFFFF_FFFF, 1'b1);
    expectStream("postrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
